// File: rtl/fp_pair_frame_ctrl_if.sv
// Byte-stream in / operand-pair out handshake bundle for fp_pair_frame_ctrl.
// master = stream source and pair consumer; slave = the frame controller.
interface fp_pair_frame_ctrl_if;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic [31:0] fp_1;
  logic [31:0] fp_2;
  logic        pair_valid;
  logic        pair_ready;

  modport master (
    output din, din_valid, pair_ready,
    input  din_ready, fp_1, fp_2, pair_valid
  );

  modport slave (
    input  din, din_valid, pair_ready,
    output din_ready, fp_1, fp_2, pair_valid
  );
endinterface

// File: rtl/fp_pair_frame_ctrl.sv
// Frames a sync byte plus 8 payload bytes into a big-endian FP operand pair, with an inter-byte timeout.
// pair_valid 1 cycle after the last byte edge; din_ready drops while the pair is held awaiting pair_ready.
module fp_pair_frame_ctrl #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  fp_pair_frame_ctrl_if.slave  bus,
  output logic                 frame_err,
  output logic                 busy,
  output logic [CNT_W-1:0]     pair_cnt
);
  typedef enum logic [1:0] {HUNT, COLLECT, HOLD} state_t;

  localparam int unsigned IDLE_W    = $clog2(TIMEOUT + 2);
  localparam int unsigned IDLE_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  state_t             state_q, state_d;
  logic [31:0]        fp_1_q, fp_1_d;
  logic [31:0]        fp_2_q, fp_2_d;
  logic               pair_valid_q, pair_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   pair_cnt_q, pair_cnt_d;
  logic [2:0]         byte_cnt_q, byte_cnt_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic               din_ready;
  logic               byte_acc;

  assign din_ready = (state_q != HOLD);
  assign byte_acc  = bus.din_valid && din_ready;

  always_comb begin
    state_d      = state_q;
    fp_1_d       = fp_1_q;
    fp_2_d       = fp_2_q;
    pair_cnt_d   = pair_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    idle_d       = idle_q;
    frame_err_d  = 1'b0;
    case (state_q)
      HUNT: begin
        if (byte_acc && bus.din == SYNC_BYTE) begin
          state_d    = COLLECT;
          byte_cnt_d = '0;
          idle_d     = '0;
        end
      end
      COLLECT: begin
        if (byte_acc) begin
          // {fp_1,fp_2} is one 64-bit shift chain; the first payload byte ends up in fp_1[31:24]
          {fp_1_d, fp_2_d} = {fp_1_q[23:0], fp_2_q, bus.din};
          byte_cnt_d       = byte_cnt_q + 1'b1;
          idle_d           = '0;
          if (byte_cnt_q == 3'd7) begin
            state_d    = HOLD;
            byte_cnt_d = '0;
          end
        end else if (TIMEOUT != 0) begin
          if (idle_q == IDLE_W'(IDLE_LAST)) begin
            state_d     = HUNT;
            frame_err_d = 1'b1;
            byte_cnt_d  = '0;
            idle_d      = '0;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (bus.pair_ready) begin
          state_d    = HUNT;
          pair_cnt_d = pair_cnt_q + 1'b1;
        end
      end
      default: state_d = HUNT;
    endcase
    pair_valid_d = (state_d == HOLD);
    busy_d       = (state_d != HUNT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= HUNT;
      fp_1_q       <= '0;
      fp_2_q       <= '0;
      pair_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
      pair_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      idle_q       <= '0;
    end else begin
      state_q      <= state_d;
      fp_1_q       <= fp_1_d;
      fp_2_q       <= fp_2_d;
      pair_valid_q <= pair_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
      pair_cnt_q   <= pair_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      idle_q       <= idle_d;
    end
  end

  assign bus.din_ready  = din_ready;
  assign bus.fp_1       = fp_1_q;
  assign bus.fp_2       = fp_2_q;
  assign bus.pair_valid = pair_valid_q;
  assign frame_err      = frame_err_q;
  assign busy           = busy_q;
  assign pair_cnt       = pair_cnt_q;
endmodule
